mem_access: RTL
===============

Name: mem_access

Overview:
- Memory-stage load/store unit; sits directly after the execute stage and is the consumer of its result, mem_rw and is_load outputs.
- Turns each accepted instruction into zero or one data-memory transaction over a req/ready + rvalid handshake.
- Aligns and sign/zero-extends load data and produces a registered writeback result.
- Stalls the upstream pipeline while a transaction is outstanding.

Parameters:
- ADDR_W, 32: data-memory byte-address width; dmem_addr = result[ADDR_W-1:0] with bits [2:0] cleared.
- XLEN, 64: datapath width; fixed at 64 (byte lanes = 8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage presents an instruction.
- result  in  64  ALU result or effective byte address.
- store_data  in  64  rs2 value for stores.
- func3  in  3  access size/sign.
- mem_rw  in  1  1 = store.
- is_load  in  1  1 = load.
- rd_in  in  5  destination register.
- stall  out  1  upstream must hold its next instruction.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_data  out  64  writeback value.
- rd_out  out  5  destination register for wb_data.
- mem_err  out  1  with wb_valid: access was rejected.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  doubleword-aligned byte address.
- dmem_wdata  out  64  lane-shifted store data.
- dmem_wstrb  out  8  byte enables.
- dmem_ready  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  64  read data.

Behaviour:
- Reset: asynchronous. State goes to IDLE; all outputs 0 (stall, wb_valid, wb_data, rd_out, mem_err, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb).
- Reset mid-transaction: dmem_req drops immediately. dmem_rvalid/rdata arriving later is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- Accept: in IDLE when ex_valid=1. All inputs are latched and decoded at the accept edge.
- stall = (state != IDLE). It is registered-state based, so it rises the cycle after accepting a memory op.
- Non-memory op (is_load=0, mem_rw=0):
  - IDLE -> RESP.
  - Next cycle: wb_valid=1, wb_data=result, mem_err=0.
  - Latency 1. RESP -> IDLE.
- Load: IDLE -> REQ.
  - dmem_req=1, dmem_we=0 held with stable address until dmem_ready=1 sampled.
  - REQ -> WAIT_R (same edge).
  - If dmem_rvalid is already 1 on the ready edge, the data is captured and the FSM goes straight to RESP.
  - In WAIT_R, capture dmem_rdata on dmem_rvalid=1 -> RESP.
- Load extract: off = addr[2:0]; shifted = dmem_rdata >> (off*8).
  - func3 000 LB, 001 LH, 010 LW, 011 LD: sign-extend.
  - func3 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - func3 111: illegal.
- Store: IDLE -> REQ with dmem_we=1, dmem_wdata = store_data << (off*8).
  - dmem_wstrb = base mask << off. Base masks: SB 0x01, SH 0x03, SW 0x0F, SD 0xFF.
  - On dmem_ready -> RESP; wb_valid=1, wb_data=0. rvalid is not awaited.
  - Store func3[2]=1 is illegal.
- Illegal (func3 illegal, or mem_rw=1 and is_load=1 together):
  - No memory request. IDLE -> RESP with mem_err=1, wb_data=0.
- RESP: lasts exactly one cycle, then IDLE.
  - A new instruction can be accepted on the cycle after RESP; a stall-free stream of ALU ops sustains one op per 2 cycles.
- rd_out is updated with the latched rd_in whenever wb_valid is asserted. wb_data/rd_out hold their value otherwise.
- Whether dmem_ready is asserted outside REQ has no effect.

Optional Feature:
- MISALIGN_TRAP_EN defined: an access with addr not aligned to its size (H: bit0, W: bits1:0, D: bits2:0) is handled like an illegal access: no request, mem_err=1.
- Not defined: low address bits below the access size are forced to 0 before lane/strobe computation. The access always proceeds; mem_err is raised only by illegal cases.

Decomposition:
- Shared package: FSM state enum; func3 encodings (F3_B/H/W/D/BU/HU/WU); opcode constants shared with the execute stage.
- One natural sub-module: mem_lane_align. It is combinational and computes store shift/strobe plus the load extract/extend from func3 and offset.

Test Plan:
- ALU pass-through: ex_valid, result=0x1234, rd_in=5 -> next cycle wb_valid=1, wb_data=0x1234, rd_out=5, no dmem_req.
- LB sign: result=0x103, func3=000, rdata=0x00000000_80000000 with ready after 2 waits, rvalid 3 cycles later -> wb_data=0xFFFFFFFF_FFFFFF80; stall high throughout.
- SH store: result=0x206, store_data=0xBEEF -> dmem_addr=0x200, wstrb=0xC0, wdata=0xBEEF<<48, we=1; wb_valid after ready, wb_data=0.
- LWU: offset 4, rdata=0xF0000001_00000000 -> wb_data=0x00000000_F0000001.
- Misaligned LW at 0x102: with MISALIGN_TRAP_EN -> mem_err=1, no req. Without -> addr 0x100, lanes [3:0] read.
- Reset asserted in WAIT_R -> dmem_req=0, stall=0 immediately; a later rvalid produces no wb_valid.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Also holds the func3 encodings and the opcodes used by the execute stage.
package mem_access_pkg;

  localparam int XLEN      = 64;
  localparam int NUM_LANES = XLEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Access context kept while a transaction is in flight.
  typedef struct packed {
    logic [2:0] func3;
    logic [2:0] off;
    logic [4:0] rd;
  } acc_t;

  function automatic logic [NUM_LANES-1:0] base_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus: req/ready request channel plus rvalid/rdata read return.
interface mem_access_if #(parameter int ADDR_W = 32);
  import mem_access_pkg::*;

  logic                 req;
  logic                 we;
  logic [ADDR_W-1:0]    addr;
  logic [XLEN-1:0]      wdata;
  logic [NUM_LANES-1:0] wstrb;
  logic                 ready;
  logic                 rvalid;
  logic [XLEN-1:0]      rdata;

  modport master (output req, we, addr, wdata, wstrb, input ready, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ready, rvalid, rdata);

endinterface

// File: rtl/mem_access_lane_align.sv
// Byte-lane alignment: store shift/strobe and load extract/extend.
// MISALIGN_TRAP_EN: report sub-size misalignment instead of silently clearing low bits.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]           func3,
  input  logic [2:0]           off,
  input  logic [XLEN-1:0]      store_data,
  input  logic [XLEN-1:0]      rdata,
  output logic [XLEN-1:0]      wdata,
  output logic [NUM_LANES-1:0] wstrb,
  output logic [XLEN-1:0]      ld_val,
  output logic                 misaligned
);

  logic [2:0]      off_eff;
  logic            mis_raw;
  logic [XLEN-1:0] sh;

  // Offset bits below the access size are dropped so lanes stay naturally aligned.
  always_comb begin
    off_eff = off;
    mis_raw = 1'b0;
    case (func3[1:0])
      2'd0: begin off_eff = off;                  mis_raw = 1'b0;           end
      2'd1: begin off_eff = {off[2:1], 1'b0};     mis_raw = off[0];         end
      2'd2: begin off_eff = {off[2], 2'b00};      mis_raw = |off[1:0];      end
      default: begin off_eff = 3'b000;            mis_raw = |off;           end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = mis_raw;
`else
  assign misaligned = 1'b0;
`endif

  assign wstrb = base_mask(func3[1:0]) << off_eff;
  assign wdata = store_data << {off_eff, 3'b000};
  assign sh    = rdata >> {off_eff, 3'b000};

  always_comb begin
    ld_val = '0;
    case (func3)
      F3_B:  ld_val = {{56{sh[7]}},  sh[7:0]};
      F3_H:  ld_val = {{48{sh[15]}}, sh[15:0]};
      F3_W:  ld_val = {{32{sh[31]}}, sh[31:0]};
      F3_D:  ld_val = sh;
      F3_BU: ld_val = {56'd0, sh[7:0]};
      F3_HU: ld_val = {48'd0, sh[15:0]};
      F3_WU: ld_val = {32'd0, sh[31:0]};
      default: ld_val = '0;
    endcase
  end

  // mis_raw is only consumed when trapping is enabled.
  logic unused_mis;
  assign unused_mis = mis_raw;

endmodule

// File: rtl/mem_access.sv
// Memory-stage load/store unit: one dmem transaction per accepted op, registered writeback.
// MISALIGN_TRAP_EN: misaligned accesses are rejected with mem_err instead of proceeding.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      func3,
  input  logic            mem_rw,
  input  logic            is_load,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      rd_out,
  output logic            mem_err,
  mem_access_if.master    dmem
);

  state_e state;
  acc_t   acc_q;

  logic                 idle;
  logic [2:0]           al_func3, al_off;
  logic [XLEN-1:0]      al_wdata, ld_val;
  logic [NUM_LANES-1:0] al_wstrb;
  logic                 al_mis;
  logic                 is_mem, illegal;

  // In IDLE the aligner decodes the incoming op; afterwards it works on the latched one.
  assign idle     = (state == IDLE);
  assign al_func3 = idle ? func3       : acc_q.func3;
  assign al_off   = idle ? result[2:0] : acc_q.off;

  mem_lane_align u_align (
    .func3      (al_func3),
    .off        (al_off),
    .store_data (store_data),
    .rdata      (dmem.rdata),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .ld_val     (ld_val),
    .misaligned (al_mis)
  );

  assign is_mem  = is_load | mem_rw;
  assign illegal = (is_load & mem_rw)
                 | (is_load & (func3 == 3'b111))
                 | (mem_rw & func3[2])
                 | (is_mem & al_mis);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc_q      <= '0;
      stall      <= 1'b0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      rd_out     <= '0;
      mem_err    <= 1'b0;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.wdata <= '0;
      dmem.wstrb <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: if (ex_valid) begin
          acc_q <= '{func3: func3, off: result[2:0], rd: rd_in};
          stall <= 1'b1;
          if (illegal || !is_mem) begin
            state    <= RESP;
            wb_valid <= 1'b1;
            wb_data  <= illegal ? '0 : result;
            mem_err  <= illegal;
            rd_out   <= rd_in;
          end else begin
            state      <= REQ;
            dmem.req   <= 1'b1;
            dmem.we    <= mem_rw;
            dmem.addr  <= {result[ADDR_W-1:3], 3'b000};
            dmem.wdata <= mem_rw ? al_wdata : '0;
            dmem.wstrb <= mem_rw ? al_wstrb : '0;
          end
        end
        REQ: if (dmem.ready) begin
          dmem.req <= 1'b0;
          // Stores complete on acceptance; loads may see data on the same edge.
          if (dmem.we || dmem.rvalid) begin
            state    <= RESP;
            wb_valid <= 1'b1;
            wb_data  <= dmem.we ? '0 : ld_val;
            mem_err  <= 1'b0;
            rd_out   <= acc_q.rd;
          end else begin
            state <= WAIT_R;
          end
        end
        WAIT_R: if (dmem.rvalid) begin
          state    <= RESP;
          wb_valid <= 1'b1;
          wb_data  <= ld_val;
          mem_err  <= 1'b0;
          rd_out   <= acc_q.rd;
        end
        RESP: begin
          state <= IDLE;
          stall <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
